// File: rtl/ysyx22041405_mem_stage_pkg.sv
// ysyx22041405_mem_stage_pkg: shared encodings and bundle widths for the MEM stage.
package ysyx22041405_mem_stage_pkg;
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    // EX/MEM: addr, wdata, mem_rd, mem_wr, size, unsigned, rd, we
    localparam int EX_MEM_W = 32 + 32 + 1 + 1 + 2 + 1 + 5 + 1;
    // MEM/WB: wdata, waddr, we, misalign
    localparam int MEM_WB_W = 32 + 5 + 1 + 1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/ysyx22041405_load_align.sv
// ysyx22041405_load_align: selects the addressed byte/half of a raw read word and extends it.
module ysyx22041405_load_align
    import ysyx22041405_mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rdata,
    input  logic [1:0]       i_addr_lo,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    output logic [WIDTH-1:0] o_data
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    assign w_b = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_h = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    assign o_data = (i_size == MEM_SIZE_B) ? {{(WIDTH-8){~i_unsigned & w_b[7]}}, w_b} :
                    (i_size == MEM_SIZE_H) ? {{(WIDTH-16){~i_unsigned & w_h[15]}}, w_h} :
                    i_rdata;
endmodule

// File: rtl/ysyx22041405_mem_stage.sv
// ysyx22041405_mem_stage: MEM stage with valid/ready data-memory bus and one-entry WB register.
// Optional MEM_MISALIGN_CHK_EN flags misaligned half/word accesses instead of issuing them.
module ysyx22041405_mem_stage
    import ysyx22041405_mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic             in_mem_rd,
    input  logic             in_mem_wr,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [4:0]       in_rf_waddr,
    input  logic             in_rf_we,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic             dm_req_we,
    output logic [WIDTH-1:0] dm_req_addr,
    output logic [WIDTH-1:0] dm_req_wdata,
    output logic [3:0]       dm_req_wstrb,
    input  logic             dm_resp_valid,
    input  logic [WIDTH-1:0] dm_resp_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rf_wdata,
    output logic [4:0]       out_rf_waddr,
    output logic             out_rf_we,
    output logic             out_misalign
);
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_req_addr, r_req_wdata, r_out_wdata, w_load;
    logic [3:0]       r_req_wstrb;
    logic [1:0]       r_lo, r_size;
    logic [4:0]       r_rd, r_out_waddr;
    logic             r_req_we, r_uns, r_rf_we;
    logic             r_out_valid, r_out_we, r_out_mis;
    logic             w_mem, w_mis, w_accept, w_issue, w_direct, w_resp;

    assign w_mem = in_mem_rd | in_mem_wr;
`ifdef MEM_MISALIGN_CHK_EN
    assign w_mis = w_mem && ((in_size == MEM_SIZE_H && in_addr[0]) ||
                             (in_size[1] && in_addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif
    assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_issue  = w_accept && w_mem && !w_mis;
    // non-mem and flagged-misaligned ops bypass the bus and complete in one cycle
    assign w_direct = w_accept && !w_issue;
    assign w_resp   = (r_state == ST_RESP) && dm_resp_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_issue ? ST_REQ : ST_IDLE;
            ST_REQ:  w_state_nxt = dm_req_ready ? ST_RESP : ST_REQ;
            ST_RESP: w_state_nxt = dm_resp_valid ? ST_IDLE : ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
            r_req_we    <= 1'b0;
            r_lo        <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_rd        <= '0;
            r_rf_we     <= 1'b0;
        end else if (w_issue) begin
            r_req_addr  <= {in_addr[WIDTH-1:2], 2'b00};
            r_req_wdata <= (in_size == MEM_SIZE_B) ? {4{in_wdata[7:0]}} :
                           (in_size == MEM_SIZE_H) ? {2{in_wdata[15:0]}} : in_wdata;
            r_req_wstrb <= (in_size == MEM_SIZE_B) ? 4'b0001 << in_addr[1:0] :
                           (in_size == MEM_SIZE_H) ? 4'b0011 << {in_addr[1], 1'b0} : 4'b1111;
            r_req_we    <= in_mem_wr;
            r_lo        <= in_addr[1:0];
            r_size      <= in_size;
            r_uns       <= in_unsigned;
            r_rd        <= in_rf_waddr;
            r_rf_we     <= in_rf_we && in_mem_rd;
        end
    end

    ysyx22041405_load_align #(.WIDTH(WIDTH)) u_load_align (
        .i_rdata    (dm_resp_rdata),
        .i_addr_lo  (r_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_wdata <= '0;
            r_out_waddr <= '0;
            r_out_we    <= 1'b0;
            r_out_mis   <= 1'b0;
        end else if (w_direct) begin
            r_out_valid <= 1'b1;
            r_out_wdata <= in_addr;
            r_out_waddr <= in_rf_waddr;
            r_out_we    <= in_rf_we && !w_mis;
            r_out_mis   <= w_mis;
        end else if (w_resp) begin
            r_out_valid <= 1'b1;
            r_out_wdata <= w_load;
            r_out_waddr <= r_rd;
            r_out_we    <= r_rf_we;
            r_out_mis   <= 1'b0;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_wdata <= '0;
            r_out_waddr <= '0;
            r_out_we    <= 1'b0;
            r_out_mis   <= 1'b0;
        end
    end

    assign dm_req_valid = (r_state == ST_REQ);
    assign dm_req_we    = r_req_we;
    assign dm_req_addr  = r_req_addr;
    assign dm_req_wdata = r_req_wdata;
    assign dm_req_wstrb = r_req_wstrb;
    assign out_valid    = r_out_valid;
    assign out_rf_wdata = r_out_wdata;
    assign out_rf_waddr = r_out_waddr;
    assign out_rf_we    = r_out_we;
    assign out_misalign = r_out_mis;
endmodule
